// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for serial_adder
package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full_adder cell, LSB first
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at Sum[0].
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign sum_next = fa_sum;
        end else begin : g_sum_multi
            assign sum_next = {fa_sum, Sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    Sum   <= sum_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    if (cnt == CNT_LAST) begin
                        Cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        Ovf   <= carry ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
// Honors SERIAL_ADDER_OVF_EN when the design is built with the Ovf output.
module tb_serial_adder;

    parameter int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        logic [63:0] s;
        s = 64'(a) + 64'(b) + 64'(c);
        return s[W:0];
    endfunction

`ifdef SERIAL_ADDER_OVF_EN
    // Overflow when the signed sum falls outside the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
        longint sa, sb, s, lim;
        lim = longint'(1) <<< (W - 1);
        sa  = a[W-1] ? longint'(64'(a)) - 2 * lim : longint'(64'(a));
        sb  = b[W-1] ? longint'(64'(b)) - 2 * lim : longint'(64'(b));
        s   = sa + sb + longint'(c);
        return (s >= lim) || (s < -lim);
    endfunction
`endif

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < W + 4 && (busy || done); i++) @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int bcyc);
        wait_idle();
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bcyc = 0;
        while (!done && lat < W + 8) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, Cout} !== 3'b000 || Sum !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b Cout=%b Sum=%h, required all zero",
                     busy, done, Cout, Sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_vec++;
        if (Ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b required 0", Ovf);
        end
`endif
    endtask

    task automatic test_directed();
        logic [7:0] ta[4] = '{8'h00, 8'hFF, 8'hA5, 8'h7F};
        logic [7:0] tb[4] = '{8'h00, 8'h01, 8'h5A, 8'h01};
        logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0] exp;
        int lat, bcyc;
        for (int i = 0; i < 4; i++) begin
            run_op(W'(ta[i]), W'(tb[i]), tc[i], lat, bcyc);
            exp = ref_add(W'(ta[i]), W'(tb[i]), tc[i]);
            n_vec++;
            if (lat !== W || done !== 1'b1) begin
                n_err++;
                $display("FAIL directed[%0d] latency: got %0d (done=%b) required %0d", i, lat, done, W);
            end
            n_vec++;
            if (bcyc !== W) begin
                n_err++;
                $display("FAIL directed[%0d] busy_cycles: got %0d required %0d", i, bcyc, W);
            end
            n_vec++;
            if ({Cout, Sum} !== exp) begin
                n_err++;
                $display("FAIL directed[%0d] result: got %b_%h required %b_%h", i, Cout, Sum, exp[W], exp[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_vec++;
            if (Ovf !== ref_ovf(W'(ta[i]), W'(tb[i]), tc[i])) begin
                n_err++;
                $display("FAIL directed[%0d] ovf: got %b required %b", i, Ovf, ref_ovf(W'(ta[i]), W'(tb[i]), tc[i]));
            end
`endif
            @(posedge clk); #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed[%0d] done_pulse: done=%b busy=%b a cycle later, required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] a, b;
        logic [W:0]   exp;
        int ndone, first, p;
        a = W'(8'h12);
        b = W'(8'h34);
        exp = ref_add(a, b, 1'b0);
        p = (W >= 3) ? 3 : W + 1;
        ndone = 0;
        first = -1;
        wait_idle();
        A = a; B = b; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 2 * W + 6; i++) begin
            start = (i == p);
            A = ~a;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone !== 1 || first !== W) begin
            n_err++;
            $display("FAIL ignored_start: %0d done pulses first at %0d, required 1 at %0d", ndone, first, W);
        end
        n_vec++;
        if ({Cout, Sum} !== exp) begin
            n_err++;
            $display("FAIL ignored_start result: got %b_%h required %b_%h", Cout, Sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$], qb[$];
        logic         qc[$];
        logic [W:0]   exp;
        int last, nd;
        last = -1;
        nd = 0;
        wait_idle();
        qa.push_back(W'($urandom)); qb.push_back(W'($urandom)); qc.push_back(1'($urandom));
        A = qa[$]; B = qb[$]; Cin = qc[$]; start = 1'b1;
        for (int i = 1; i <= 4 * (W + 2) + 4 && nd < 4; i++) begin
            @(posedge clk); #1;
            if (done) begin
                exp = ref_add(qa[0], qb[0], qc[0]);
                void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
                n_vec++;
                if ({Cout, Sum} !== exp) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d] result: got %b_%h required %b_%h", nd, Cout, Sum, exp[W], exp[W-1:0]);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (i - last !== W + 2) begin
                        n_err++;
                        $display("FAIL back_to_back[%0d] period: got %0d required %0d", nd, i - last, W + 2);
                    end
                end
                last = i;
                nd++;
                qa.push_back(W'($urandom)); qb.push_back(W'($urandom)); qc.push_back(1'($urandom));
                A = qa[$]; B = qb[$]; Cin = qc[$];
            end
        end
        start = 1'b0;
        n_vec++;
        if (nd !== 4) begin
            n_err++;
            $display("FAIL back_to_back count: got %0d done pulses required 4", nd);
        end
    endtask

    task automatic test_reset_mid();
        logic [W:0] exp;
        int lat, bcyc, nd;
        wait_idle();
        A = W'(8'hC3); B = W'(8'h9E); Cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W / 2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, Cout} !== 3'b000 || Sum !== '0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b Cout=%b Sum=%h, required all zero", busy, done, Cout, Sum);
        end
        nd = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        n_vec++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL reset_mid abandoned: got %0d active cycles required 0", nd);
        end
        run_op(W'(8'h01), W'(8'h01), 1'b0, lat, bcyc);
        exp = ref_add(W'(8'h01), W'(8'h01), 1'b0);
        n_vec++;
        if (lat !== W || {Cout, Sum} !== exp) begin
            n_err++;
            $display("FAIL reset_mid recovery: lat=%0d got %b_%h required lat=%0d %b_%h", lat, Cout, Sum, W, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        int lat, bcyc;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            run_op(a, b, c, lat, bcyc);
            exp = ref_add(a, b, c);
            n_vec++;
            if (lat !== W || done !== 1'b1) begin
                n_err++;
                $display("FAIL random[%0d] latency: got %0d required %0d", n, lat, W);
            end
            n_vec++;
            if ({Cout, Sum} !== exp) begin
                n_err++;
                $display("FAIL random[%0d] %h+%h+%b: got %b_%h required %b_%h", n, a, b, c, Cout, Sum, exp[W], exp[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_vec++;
            if (Ovf !== ref_ovf(a, b, c)) begin
                n_err++;
                $display("FAIL random[%0d] ovf: got %b required %b", n, Ovf, ref_ovf(a, b, c));
            end
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
